prio_arb_enc: RTL

Parametrised, registered priority encoder and arbiter. It generalises the 8-to-3 combinational encoder to N request lines and adds two selectable arbitration modes: fixed (highest index wins) and round-robin. The winning grant is held in an output register behind a valid/ready handshake. It sits between request sources, such as interrupt or bus-master lines, and a single consumer that takes one grant at a time.

---
 rtl/prio_arb_enc.sv | 81 ++++++++
 1 files changed

// File: rtl/prio_arb_enc.sv
// Registered N-way priority encoder/arbiter with fixed or round-robin selection.
// The winning index is held behind a valid/ready handshake until the consumer takes it.
module prio_arb_enc #(
  parameter  int unsigned N     = 8,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             mode,
  input  logic [N-1:0]     req,
  output logic             any_req,
  output logic             gnt_valid,
  input  logic             gnt_ready,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N-1:0]     gnt_onehot,
  output logic [IDX_W-1:0] rr_ptr
);

  logic             r_valid;
  logic [IDX_W-1:0] r_idx;
  logic [N-1:0]     r_onehot;
  logic [IDX_W-1:0] r_rr_ptr;

  logic             w_any;
  logic             w_capture;
  logic [IDX_W-1:0] w_fix_idx;
  logic [IDX_W-1:0] w_rr_idx;
  logic [IDX_W-1:0] w_rr_pos;
  logic [IDX_W-1:0] w_sel_idx;

  assign w_any     = |req;
  assign w_capture = ena & w_any & (~r_valid | gnt_ready);

  // Fixed priority: the last set bit seen in an ascending scan is the highest.
  always_comb begin
    w_fix_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) w_fix_idx = IDX_W'(i);
    end
  end

  // Round-robin: scan from the far end of the search order so the nearest
  // set bit at or below rr_ptr (with wrap) is written last.
  always_comb begin
    w_rr_idx = '0;
    w_rr_pos = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_rr_pos = IDX_W'((int'(r_rr_ptr) + int'(N) - k) % int'(N));
      if (req[w_rr_pos]) w_rr_idx = w_rr_pos;
    end
  end

  assign w_sel_idx = mode ? w_rr_idx : w_fix_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_idx    <= '0;
      r_onehot <= '0;
      r_rr_ptr <= IDX_W'(N - 1);
    end else if (w_capture) begin
      r_valid  <= 1'b1;
      r_idx    <= w_sel_idx;
      r_onehot <= N'(1) << w_sel_idx;
      if (mode) begin
        r_rr_ptr <= (w_sel_idx == '0) ? IDX_W'(N - 1) : w_sel_idx - IDX_W'(1);
      end
    end else if (r_valid && gnt_ready) begin
      r_valid  <= 1'b0;
      r_onehot <= '0;
    end
  end

  assign any_req    = w_any;
  assign gnt_valid  = r_valid;
  assign gnt_idx    = r_idx;
  assign gnt_onehot = r_onehot;
  assign rr_ptr     = r_rr_ptr;

endmodule
